// File: rtl/entropy_dispatch_ctrl.sv
// Dispatches checked-noise FIFO words to the seed and raw consumers.
// Handles warm-up discard, seed/raw arbitration and health-failure escalation.
module entropy_dispatch_ctrl #(
  parameter int DATA_W       = 256,
  parameter int WARMUP_WORDS = 4,
  parameter int FAIL_LIMIT   = 4,
  parameter int FAIL_CLEAR   = 16,
  parameter int STARVE_MAX   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              good_entropy,
  input  logic              inter_fail,
  input  logic              perm_fail,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_deque,
  input  logic              debug_mode,
  input  logic              seed_req,
  output logic              seed_ack,
  input  logic              raw_req,
  output logic              raw_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              alarm,
  output logic              lockout,
  output logic [2:0]        fail_count,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WARMUP = 3'd1, READY = 3'd2, ISSUE = 3'd3,
    ACK = 3'd4, ALARM = 3'd5, LOCKOUT = 3'd6
  } state_t;

  localparam int WW = $clog2(WARMUP_WORDS + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(FAIL_CLEAR + 1);

  state_t            st, st_n;
  logic [WW-1:0]     warm_cnt, warm_n;
  logic [SW-1:0]     starve_cnt, starve_n;
  logic [CW-1:0]     succ_cnt, succ_n;
  logic [2:0]        fail_n, fail_inc;
  logic              grant_raw, grant_n;
  logic [DATA_W-1:0] data_n;
  logic              fail, avail, seed_elig, raw_elig, pick_raw;

  assign fail      = inter_fail | perm_fail;
  assign avail     = !fifo_empty && good_entropy;
  assign seed_elig = seed_req;
  assign raw_elig  = raw_req && debug_mode;
  assign fail_inc  = (fail_count == 3'd7) ? 3'd7 : fail_count + 3'd1;

  always_comb begin
    st_n       = st;
    warm_n     = warm_cnt;
    starve_n   = raw_elig ? starve_cnt : '0;
    succ_n     = succ_cnt;
    fail_n     = fail_count;
    grant_n    = grant_raw;
    data_n     = data_out;
    pick_raw   = 1'b0;
    fifo_deque = 1'b0;
    seed_ack   = 1'b0;
    raw_ack    = 1'b0;
    case (st)
      IDLE: st_n = WARMUP;
      WARMUP: if (avail) begin
        fifo_deque = 1'b1;
        warm_n     = warm_cnt + 1'b1;
        if (warm_cnt == WW'(WARMUP_WORDS - 1)) st_n = READY;
      end
      READY: if (avail && (seed_elig || raw_elig)) begin
        pick_raw = raw_elig && (!seed_elig || starve_cnt == SW'(STARVE_MAX));
        grant_n  = pick_raw;
        st_n     = ISSUE;
        if (pick_raw)      starve_n = '0;
        else if (raw_elig) starve_n = starve_cnt + 1'b1;
      end
      // Hold in ISSUE if the head vanished so an ack always follows a real pop.
      ISSUE: if (!fifo_empty) begin
        fifo_deque = 1'b1;
        data_n     = fifo_rdata;
        st_n       = ACK;
      end
      ACK: begin
        st_n     = READY;
        raw_ack  = grant_raw;
        seed_ack = !grant_raw;
        if (succ_cnt == CW'(FAIL_CLEAR - 1)) begin
          succ_n = '0;
          fail_n = '0;
        end else begin
          succ_n = succ_cnt + 1'b1;
        end
      end
      ALARM: if (!fail && good_entropy) begin
        st_n   = WARMUP;
        warm_n = '0;
      end
      LOCKOUT: ;
      default: st_n = IDLE;
    endcase

    // A new failure episode overrides everything; fails held in ALARM are one episode.
    if (fail && st != LOCKOUT && st != ALARM) begin
      seed_ack = 1'b0;
      raw_ack  = 1'b0;
      succ_n   = '0;
      fail_n   = fail_inc;
      st_n     = (fail_inc >= 3'(FAIL_LIMIT)) ? LOCKOUT : ALARM;
      if (st == WARMUP) begin
        fifo_deque = 1'b0;
        warm_n     = warm_cnt;
      end
      if (st == READY) starve_n = raw_elig ? starve_cnt : '0;
    end

    if (rst) begin
      fifo_deque = 1'b0;
      seed_ack   = 1'b0;
      raw_ack    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      warm_cnt   <= '0;
      starve_cnt <= '0;
      succ_cnt   <= '0;
      fail_count <= '0;
      grant_raw  <= 1'b0;
      data_out   <= '0;
    end else begin
      st         <= st_n;
      warm_cnt   <= warm_n;
      starve_cnt <= starve_n;
      succ_cnt   <= succ_n;
      fail_count <= fail_n;
      grant_raw  <= grant_n;
      data_out   <= data_n;
    end
  end

  assign alarm   = (st == ALARM);
  assign lockout = (st == LOCKOUT);
  assign state   = st;
endmodule
